fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Instruction-fetch front end and producer side of the decode interface.
- Issues in-order word reads to instruction memory and buffers returned instructions with their PCs.
- Presents one instruction per cycle to decode with a valid/ready handshake, pre-split into op, funct3 and funct7 (bit 30) for the control decoder.
- Handles branch/jump redirects by flushing buffered and in-flight fetches.

Parameters:
XLEN, 32, address and instruction width
DEPTH, 4, buffer entries (power of two, ≥2); also the maximum of outstanding plus buffered fetches
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  word-aligned fetch address
imem_rsp_valid  in  1  response valid; responses return in request order, latency ≥1, no backpressure
imem_rsp_data  in  XLEN  fetched instruction
redirect  in  1  branch/jump taken, flush and refetch
redirect_pc  in  XLEN  new fetch target
instr_valid  out  1  instruction available to decode
instr_ready  in  1  decode consumes instruction
instr  out  XLEN  head instruction
instr_pc  out  XLEN  PC of head instruction
op  out  7  instr[6:0]
funct3  out  3  instr[14:12]
funct7  out  1  instr[30]

Behaviour:
- Reset (synchronous, active-high; may occur mid-operation):
  - fetch_pc=RESET_PC; buffer empty; outstanding=0; state=RUN.
  - imem_req_valid=0 and instr_valid=0 during the reset cycle.
  - Responses arriving during or after reset for pre-reset requests are not tracked and are ignored.
- States:
  - RUN: normal operation.
  - DRAIN: entered on redirect when outstanding>0 after that cycle's accounting. Requests are suppressed and every response is discarded with outstanding decremented. Return to RUN the cycle after outstanding reaches 0.
- Issue rule: imem_req_valid=1 iff state=RUN, no redirect this cycle, and outstanding+count<DEPTH.
  - Handshake completes when imem_req_valid&&imem_req_ready.
  - On handshake: store fetch_pc into PC tag FIFO, fetch_pc+=4 (wraps modulo 2^XLEN), outstanding++.
  - imem_req_addr=fetch_pc, held stable while valid && !ready.
- Response (RUN): write {imem_rsp_data, tag PC} into the buffer, outstanding--. Space is guaranteed by the credit rule, so responses are never dropped.
- Output:
  - instr_valid = count>0; head fields are combinational from the head entry.
  - Pop on instr_valid&&instr_ready.
  - Simultaneous push and pop keeps count unchanged.
  - Empty buffer with a same-cycle response does not bypass: the instruction appears the next cycle. Minimum fetch-to-decode latency is memory latency +1.
- Redirect (highest priority):
  - Clear buffer and tag FIFO; instr_valid=0 next cycle; same-cycle pop and push are discarded.
  - fetch_pc=redirect_pc; no request issued in the redirect cycle.
  - Next state is DRAIN if outstanding (including a same-cycle handshake, minus a same-cycle response) >0, else RUN.
  - Redirect during DRAIN: reload fetch_pc and remain in DRAIN.
- redirect_pc[1:0] is used as given; alignment is the caller's responsibility.
- Full buffer (count=DEPTH): no requests; hold until pop. Stall with instr_ready=0 keeps head fields stable.

Optional Feature:
- Macro: FETCH_QUEUE_PERF_CNT_EN.
- Defined: adds output ports perf_flush_cnt (32), the number of redirects, and perf_drop_cnt (32), the number of responses discarded in DRAIN. Both reset to 0, wrap at 2^32, and increment in the same cycle as the event.
- Undefined: no such ports, no counter logic; behaviour otherwise identical.

Test Plan:
- Reset, memory latency 1, instr_ready=1 → requests at 0x0,0x4,0x8…; first instr_valid 2 cycles after first handshake; instr_pc tracks request address, op/funct3/funct7 match the data.
- instr_ready=0 with DEPTH=4 → exactly 4 handshakes, then imem_req_valid=0; head holds 0x0. Release ready → one pop per cycle, issue resumes.
- Latency 3, redirect to 0x100 with 2 outstanding → state DRAIN, 2 responses dropped, instr_valid stays 0; first new request 0x100 issued the cycle after the last drop.
- Redirect coincident with a pop and a response, outstanding=0 → buffer empty next cycle; request 0x100 next cycle; no stale instruction delivered.
- imem_req_ready=0 for 5 cycles → imem_req_addr stable at its value; exactly one handshake when ready rises.
- Reset asserted in DRAIN with 1 outstanding → next cycle request 0x0 (RESET_PC); late response ignored; with macro defined both counters read 0.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues in-order word reads, buffers {instr, pc}, feeds decode.
// Optional redirect/drop performance counters are enabled by defining FETCH_QUEUE_PERF_CNT_EN.
module fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [6:0]      op,
  output logic [2:0]      funct3,
`ifdef FETCH_QUEUE_PERF_CNT_EN
  output logic [31:0]     perf_flush_cnt,
  output logic [31:0]     perf_drop_cnt,
`endif
  output logic            funct7
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {RUN, DRAIN} state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
  } entry_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   count_q;
  logic [PW-1:0]   tag_wr_q, tag_rd_q;
  logic [PW-1:0]   head_q, tail_q;
  logic [XLEN-1:0] tag_mem [DEPTH];
  entry_t          ent_mem [DEPTH];

  logic [CW:0]     occupancy;
  logic            req_fire;
  logic            rsp_take;
  logic            push;
  logic            pop;
  entry_t          head_ent;

  // Credit check: in-flight plus buffered never exceeds DEPTH, so responses always fit.
  always_comb begin
    occupancy      = {1'b0, outstanding_q} + {1'b0, count_q};
    imem_req_valid = (state_q == RUN) && !redirect && !reset
                     && (occupancy < (CW+1)'(DEPTH));
    imem_req_addr  = fetch_pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_take       = imem_rsp_valid && (outstanding_q != '0);
    push           = rsp_take && (state_q == RUN) && !redirect;
    instr_valid    = (count_q != '0) && !reset;
    pop            = instr_valid && instr_ready && !redirect;
    outstanding_d  = outstanding_q + CW'(req_fire) - CW'(rsp_take);
  end

  // Decode-side view of the head entry.
  always_comb begin
    head_ent = ent_mem[head_q];
    instr    = head_ent.data;
    instr_pc = head_ent.pc;
    op       = head_ent.data[6:0];
    funct3   = head_ent.data[14:12];
    funct7   = head_ent.data[30];
  end

  // Next state: drain stale responses after a redirect while any are still in flight.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (redirect && (outstanding_d != '0)) state_d = DRAIN;
      DRAIN:   state_d = (outstanding_d != '0) ? DRAIN : RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Fetch PC, credit counter and queue pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      count_q       <= '0;
      tag_wr_q      <= '0;
      tag_rd_q      <= '0;
      head_q        <= '0;
      tail_q        <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      if (redirect) begin
        fetch_pc_q <= redirect_pc;
        count_q    <= '0;
        tag_wr_q   <= '0;
        tag_rd_q   <= '0;
        head_q     <= '0;
        tail_q     <= '0;
      end else begin
        if (req_fire) begin
          fetch_pc_q <= fetch_pc_q + XLEN'(4);
          tag_wr_q   <= tag_wr_q + PW'(1);
        end
        if (push) begin
          tail_q   <= tail_q + PW'(1);
          tag_rd_q <= tag_rd_q + PW'(1);
        end
        if (pop) head_q <= head_q + PW'(1);
        count_q <= count_q + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage arrays carry no reset; validity is tracked by the pointers above.
  always_ff @(posedge clk) begin
    if (req_fire) tag_mem[tag_wr_q] <= fetch_pc_q;
    if (push)     ent_mem[tail_q]   <= '{pc: tag_mem[tag_rd_q], data: imem_rsp_data};
  end

`ifdef FETCH_QUEUE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_flush_cnt <= '0;
      perf_drop_cnt  <= '0;
    end else begin
      perf_flush_cnt <= perf_flush_cnt + 32'(redirect);
      perf_drop_cnt  <= perf_drop_cnt + 32'(rsp_take && (state_q == DRAIN));
    end
  end
`endif

endmodule
